// File: rtl/spi_xfer_sequencer_pkg.sv
// Shared definitions for the SPI transfer sequencer: register map, CTRL/STATUS
// bit positions, the clear-done value and the sequencer state encoding.
package spi_xfer_sequencer_pkg;

    localparam logic [1:0] RegCtrl    = 2'b00;
    localparam logic [1:0] RegSend    = 2'b01;
    localparam logic [1:0] RegReceive = 2'b10;
    localparam logic [1:0] RegStatus  = 2'b11;

    localparam int unsigned CtrlDoneIntEn   = 7;
    localparam int unsigned CtrlSpiMode     = 6;
    localparam int unsigned CtrlProcess     = 5;
    localparam int unsigned CtrlPrescalerHi = 4;
    localparam int unsigned CtrlPrescalerLo = 2;
    localparam int unsigned CtrlCpol        = 1;
    localparam int unsigned CtrlCpha        = 0;

    localparam int unsigned StatusDone  = 7;
    localparam int unsigned StatusReady = 6;
    localparam int unsigned StatusBusy  = 5;

    localparam logic [7:0] StatusClrDone = 8'h80;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StClr  = 3'd1,
        StSend = 3'd2,
        StGo   = 3'd3,
        StStop = 3'd4,
        StPoll = 3'd5,
        StRdrx = 3'd6,
        StResp = 3'd7
    } state_e;

    // done_int_en is never set: completion is always found by polling
    function automatic logic [7:0] ctrl_word(input logic       spi_mode,
                                             input logic       process,
                                             input logic [2:0] prescaler,
                                             input logic       cpol,
                                             input logic       cpha);
        return {1'b0, spi_mode, process, prescaler, cpol, cpha};
    endfunction

endpackage

// File: rtl/spi_xfer_sequencer.sv
// Register-bus master that turns one byte command into the full SPI core
// access sequence and returns the received byte on a valid/ready port.
module spi_xfer_sequencer
    import spi_xfer_sequencer_pkg::*;
#(
    parameter logic [2:0]  PRESCALER      = 3'd2,
    parameter logic        CPOL           = 1'b0,
    parameter logic        CPHA           = 1'b0,
    parameter logic        SPI_MODE       = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TIMEOUT_W      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       busy,
    output logic       reg_enable,
    output logic       reg_write_enable,
    output logic [1:0] reg_address,
    output logic [7:0] reg_write_data,
    input  logic [7:0] reg_read_data
);

    localparam logic [TIMEOUT_W-1:0] CntLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] CtrlGo   = ctrl_word(SPI_MODE, 1'b1, PRESCALER, CPOL, CPHA);
    localparam logic [7:0] CtrlIdle = ctrl_word(SPI_MODE, 1'b0, PRESCALER, CPOL, CPHA);

    state_e               state_q, state_d;
    logic [7:0]           tx_q, tx_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [7:0]           rsp_data_q, rsp_data_d;
    logic                 rsp_timeout_q, rsp_timeout_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            tx_q          <= 8'h00;
            cnt_q         <= '0;
            rsp_data_q    <= 8'h00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_q          <= tx_d;
            cnt_q         <= cnt_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Bus and handshake outputs depend on state_q only; reg_read_data only steers next state
    always_comb begin
        state_d          = state_q;
        tx_d             = tx_q;
        cnt_d            = cnt_q;
        rsp_data_d       = rsp_data_q;
        rsp_timeout_d    = rsp_timeout_q;
        cmd_ready        = 1'b0;
        rsp_valid        = 1'b0;
        reg_enable       = 1'b0;
        reg_write_enable = 1'b0;
        reg_address      = 2'b00;
        reg_write_data   = 8'h00;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    tx_d    = cmd_data;
                    state_d = StClr;
                end
            end
            StClr: begin
                reg_enable       = 1'b1;
                reg_write_enable = 1'b1;
                reg_address      = RegStatus;
                reg_write_data   = StatusClrDone;
                state_d          = StSend;
            end
            StSend: begin
                reg_enable       = 1'b1;
                reg_write_enable = 1'b1;
                reg_address      = RegSend;
                reg_write_data   = tx_q;
                state_d          = StGo;
            end
            StGo: begin
                reg_enable       = 1'b1;
                reg_write_enable = 1'b1;
                reg_address      = RegCtrl;
                reg_write_data   = CtrlGo;
                state_d          = StStop;
            end
            StStop: begin
                reg_enable       = 1'b1;
                reg_write_enable = 1'b1;
                reg_address      = RegCtrl;
                reg_write_data   = CtrlIdle;
                cnt_d            = '0;
                state_d          = StPoll;
            end
            StPoll: begin
                reg_enable  = 1'b1;
                reg_address = RegStatus;
                if (reg_read_data[StatusDone]) begin
                    state_d = StRdrx;
                end else if (cnt_q == CntLast) begin
                    rsp_data_d    = 8'h00;
                    rsp_timeout_d = 1'b1;
                    state_d       = StResp;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            StRdrx: begin
                reg_enable    = 1'b1;
                reg_address   = RegReceive;
                rsp_data_d    = reg_read_data;
                rsp_timeout_d = 1'b0;
                state_d       = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Scoreboard bench for spi_xfer_sequencer against a small SPI register-block model.
module tb_spi_xfer_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       busy;
    logic       reg_enable;
    logic       reg_write_enable;
    logic [1:0] reg_address;
    logic [7:0] reg_write_data;
    logic [7:0] reg_read_data;

    always #5 clk = ~clk;

    spi_xfer_sequencer #(
        .PRESCALER     (3'd2),
        .CPOL          (1'b0),
        .CPHA          (1'b0),
        .SPI_MODE      (1'b0),
        .TIMEOUT_CYCLES(8),
        .TIMEOUT_W     (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_data        (cmd_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_timeout     (rsp_timeout),
        .busy            (busy),
        .reg_enable      (reg_enable),
        .reg_write_enable(reg_write_enable),
        .reg_address     (reg_address),
        .reg_write_data  (reg_write_data),
        .reg_read_data   (reg_read_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Register-block model: done rises 'delay' cycles after the process write
    int         cyc = 0;
    int         delay = 3;
    logic       done_en = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       stale_set = 1'b0;
    logic       stale_q, pending_q;
    int         proc_cyc;
    int         proc_hi = 0;
    int         status_reads = 0;
    logic [9:0] wlog[$];
    logic       done_vis;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stale_q   <= 1'b0;
            pending_q <= 1'b0;
            proc_cyc  <= 0;
        end else begin
            if (stale_set) stale_q <= 1'b1;
            if (reg_enable && reg_write_enable) begin
                wlog.push_back({reg_address, reg_write_data});
                if (reg_address == 2'b11 && reg_write_data[7]) begin
                    stale_q   <= 1'b0;
                    pending_q <= 1'b0;
                end
                if (reg_address == 2'b00 && reg_write_data[5]) begin
                    pending_q <= done_en;
                    proc_cyc  <= cyc;
                    proc_hi   <= proc_hi + 1;
                end
            end
            if (reg_enable && !reg_write_enable && reg_address == 2'b11)
                status_reads <= status_reads + 1;
        end
    end

    assign done_vis = stale_q | (pending_q && ((cyc - proc_cyc) >= delay));
    assign reg_read_data = (reg_address == 2'b11) ? {done_vis, 1'b1, 6'b0} :
                           (reg_address == 2'b10) ? rx_byte : 8'h00;

    // Scoreboard
    typedef struct {
        logic [7:0] data;
        logic       to;
        int         lat;
    } exp_t;
    exp_t sb[$];

    int   acc_cyc = 0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (rsp_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                    check("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
                end
            end
            prev_valid = rsp_valid;
        end
    end

    task automatic issue(input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_data  = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic to, input int lat);
        exp_t e;
        e.data = d;
        e.to   = to;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic wait_rsp();
        int i;
        for (i = 0; i < 200; i++) begin
            if (rsp_valid) break;
            @(posedge clk); #1;
        end
        if (!rsp_valid) check("rsp_wait_bound", 32'd0, 32'd1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    int base_w, base_p, base_s;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_reg_enable", 32'(reg_enable), 32'd0);
        check("rst_bus", {22'd0, reg_address, reg_write_data}, 32'd0);
        check("rst_rsp", {23'd0, rsp_timeout, rsp_data}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Loopback: done 3 cycles after process, RECEIVE=5A
        base_w = wlog.size(); base_p = proc_hi;
        delay = 3; done_en = 1'b1; rx_byte = 8'h5A;
        push_exp(8'h5A, 1'b0, 8);
        issue(8'hA5);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_rsp();
        consume();
        check("wr_count", 32'(wlog.size() - base_w), 32'd4);
        if (wlog.size() - base_w == 4) begin
            check("wr0_status_clr", 32'(wlog[base_w]), 32'h380);
            check("wr1_send", 32'(wlog[base_w+1]), 32'h1A5);
            check("wr2_ctrl_go", 32'(wlog[base_w+2]), 32'h028);
            check("wr3_ctrl_stop", 32'(wlog[base_w+3]), 32'h008);
        end
        check("process_pulses", 32'(proc_hi - base_p), 32'd1);

        // Done on first POLL read: minimum latency
        base_p = proc_hi;
        delay = 2; rx_byte = 8'h3C;
        push_exp(8'h3C, 1'b0, 7);
        issue(8'h11);
        wait_rsp();
        consume();
        check("process_pulses_min", 32'(proc_hi - base_p), 32'd1);

        // Done never set: timeout after 8 STATUS reads
        base_s = status_reads;
        done_en = 1'b0;
        push_exp(8'h00, 1'b1, 13);
        issue(8'h77);
        wait_rsp();
        consume();
        check("timeout_status_reads", 32'(status_reads - base_s), 32'd8);

        // Response backpressure with a queued command
        done_en = 1'b1; delay = 2; rx_byte = 8'hC3;
        push_exp(8'hC3, 1'b0, 7);
        issue(8'h99);
        wait_rsp();
        rx_byte = 8'h24;
        push_exp(8'h24, 1'b0, 7);
        cmd_valid = 1'b1; cmd_data = 8'h42;
        for (int i = 0; i < 10; i++) begin
            check("stall_rsp_data", 32'(rsp_data), 32'hC3);
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        consume();
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("next_accepted", 32'(busy), 32'd1);
        wait_rsp();
        consume();

        // Stale done before the command must be cleared first
        base_w = wlog.size();
        stale_set = 1'b1;
        @(posedge clk); #1;
        stale_set = 1'b0;
        check("stale_visible", 32'(done_vis), 32'd1);
        delay = 3; rx_byte = 8'h6B;
        push_exp(8'h6B, 1'b0, 8);
        issue(8'h5E);
        wait_rsp();
        consume();
        if (wlog.size() - base_w >= 2) begin
            check("stale_wr0_clr", 32'(wlog[base_w]), 32'h380);
            check("stale_wr1_send", 32'(wlog[base_w+1]), 32'h15E);
        end else begin
            check("stale_wr_count", 32'(wlog.size() - base_w), 32'd4);
        end

        // Reset asserted during POLL
        done_en = 1'b0;
        issue(8'h13);
        repeat (6) @(posedge clk);
        #1;
        check("poll_bus", {29'd0, reg_enable, reg_address}, 32'h7);
        rst = 1'b0;
        #2;
        check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_reg_enable", 32'(reg_enable), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", 32'(cmd_ready), 32'd1);
        done_en = 1'b1; delay = 2; rx_byte = 8'h81;
        push_exp(8'h81, 1'b0, 7);
        issue(8'h18);
        wait_rsp();
        consume();

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
